// File: rtl/if_stage_if.sv
// Bundles the fetch stage's instruction-memory, redirect and decode handshakes.
// The master modport is the fetch stage. The slave modport is the memory/decoder side.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. It keeps one memory request in flight and buffers
// fetched {pc, instr} pairs in a 2-entry FIFO toward the decoder.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic         clk,
   input logic         rst,
   if_stage_if.master  bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;

   logic        rvalid_wait;
   logic        push;
   logic        pop;
   logic [2:0]  occ;
   logic        req_ok;
   logic        grant;
   logic        tail;

   always_comb begin
      rvalid_wait = (state_q == WAIT) && bus.imem_rvalid;
      push        = rvalid_wait && !bus.redirect_valid;
      pop         = (count_q != 2'd0) && bus.id_ready && !bus.redirect_valid;
      // Occupancy after this cycle's push/pop decides whether a new fetch fits.
      occ         = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
      req_ok      = !bus.redirect_valid && ((state_q == IDLE) || rvalid_wait) && (occ < 3'd2);
      grant       = req_ok && bus.imem_gnt;

      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      count_d  = count_q;
      head_d   = head_q;

      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_pc & 32'hFFFF_FFFC;
         count_d = 2'd0;
         head_d  = 1'b0;
         // An in-flight request whose data has not arrived must be drained.
         if (state_q != IDLE) begin
            state_d = bus.imem_rvalid ? IDLE : DROP;
         end
      end else begin
         count_d = occ[1:0];
         if (pop) begin
            head_d = ~head_q;
         end
         if ((state_q != IDLE) && bus.imem_rvalid) begin
            state_d = IDLE;
         end
         if (grant) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = WAIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         count_q  <= 2'd0;
         head_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   // With count < 2 whenever push is possible, the tail slot is head + count.
   assign tail = head_q ^ count_q[0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic        wr;
         logic [31:0] entry_pc_q, entry_pc_d;
         logic [31:0] entry_instr_q, entry_instr_d;

         assign wr = push && (tail == 1'(gi));

         always_comb begin
            entry_pc_d    = entry_pc_q;
            entry_instr_d = entry_instr_q;
            if (wr) begin
               entry_pc_d    = req_pc_q;
               entry_instr_d = bus.imem_rdata;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               entry_pc_q    <= '0;
               entry_instr_q <= '0;
            end else begin
               entry_pc_q    <= entry_pc_d;
               entry_instr_q <= entry_instr_d;
            end
         end
      end
   endgenerate

   assign bus.imem_req  = req_ok && !rst;
   assign bus.imem_addr = pc_q;
   assign bus.id_valid  = (count_q != 2'd0) && !rst;
   assign bus.id_pc     = rst ? 32'd0 :
                          (head_q ? g_entry[1].entry_pc_q : g_entry[0].entry_pc_q);
   assign bus.id_instr  = rst ? 32'd0 :
                          (head_q ? g_entry[1].entry_instr_q : g_entry[0].entry_instr_q);
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port imem_req  output  1  SHALL signal an instruction-memory read request.
REQ-005 Port imem_addr  output  32  SHALL carry the request word address (bits[1:0] always 00).
REQ-006 Port imem_gnt  input  1  SHALL mark request acceptance; a handshake completes when imem_req && imem_gnt.
REQ-007 Port imem_rvalid  input  1  SHALL mark read data valid, at least 1 cycle after the grant.
REQ-008 Port imem_rdata  input  32  SHALL carry the instruction word when imem_rvalid=1.
REQ-009 Port redirect_valid  input  1  SHALL request a PC redirect (taken jal/jalr/branch).
REQ-010 Port redirect_pc  input  32  SHALL carry the redirect target; bits[1:0] are ignored and forced to 00.
REQ-011 Port id_valid  output  1  SHALL mark a valid instruction toward the decoder.
REQ-012 Port id_ready  input  1  SHALL mark decoder acceptance; a transfer completes when id_valid && id_ready.
REQ-013 Port id_instr  output  32  SHALL carry the instruction word for the control decoder.
REQ-014 Port id_pc  output  32  SHALL carry the address id_instr was fetched from.

Function
REQ-015 Fetched entries SHALL be buffered in a 2-entry in-order FIFO of {pc, instr}; id_valid SHALL equal (count != 0), and id_instr/id_pc SHALL show the head entry.
REQ-016 At most one memory request SHALL be outstanding; the FSM states are IDLE (none outstanding), WAIT (outstanding, keep response), and DROP (outstanding, discard response).
REQ-017 When no redirect is present, imem_req SHALL be 1 iff (state==IDLE, or state==WAIT with imem_rvalid=1) and (count + push - pop) < 2 in that cycle.
REQ-018 imem_addr SHALL equal the pc register; pc and imem_req SHALL be held stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-019 On grant: pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), the granted address SHALL be latched as req_pc, and the state SHALL go to WAIT.
REQ-020 In WAIT with imem_rvalid=1 and no redirect: {req_pc, imem_rdata} SHALL be pushed, and the state SHALL go to IDLE unless a new grant occurs in the same cycle (WAIT).
REQ-021 imem_rvalid in IDLE SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order; push with count==2 SHALL be impossible by REQ-017.
REQ-023 A redirect SHALL have highest priority: count <= 0, pc <= {redirect_pc[31:2],2'b00}, and imem_req=0 in that cycle; any simultaneous pop or push SHALL be discarded.
REQ-024 On redirect, the next state SHALL be: IDLE if state is IDLE; DROP if state is WAIT without rvalid; IDLE if state is WAIT with rvalid (data discarded); DROP if state is DROP.
REQ-025 In DROP, imem_rvalid SHALL discard the data and move the state to IDLE; no request is issued in that cycle.
REQ-026 Best-case throughput SHALL be one instruction per cycle when the memory grants immediately and returns 1 cycle later; fetch-to-id_valid latency is 1 cycle after rvalid.

Reset
REQ-027 While rst=1: pc=RESET_PC, state=IDLE, count=0, imem_req=0, id_valid=0; id_instr/id_pc SHALL read 0.
REQ-028 rst asserted mid-transaction SHALL abandon the outstanding request; a response arriving after reset release in IDLE SHALL be ignored per REQ-021.
REQ-029 The first imem_req=1 with imem_addr=RESET_PC SHALL occur in the first cycle after rst deasserts.

Verification
REQ-030 Reset release, gnt always 1, rvalid 1 cycle after grant, id_ready=1 -> addresses 0x3000, 0x3004, 0x3008 requested on consecutive cycles; id_pc follows the same sequence with one instruction per cycle.
REQ-031 id_ready=0 for 5 cycles -> FIFO fills to 2 and imem_req drops to 0; id_ready=1 -> entries drain in order, then fetching resumes with no lost or duplicated pc.
REQ-032 imem_gnt=0 for 3 cycles -> imem_req=1 and imem_addr is stable for all 3 cycles; pc does not advance until the grant.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_3103 while in WAIT and 2 cycles before rvalid -> id_valid=0 next cycle; the late rdata is dropped; next request address is 0x3100.
REQ-034 redirect coincident with rvalid and id_ready=1 -> the FIFO is empty next cycle, the state is IDLE, and the next request goes to the redirect target.
REQ-035 pc=32'hFFFF_FFFC granted -> next request address is 32'h0000_0000, and id_pc of that entry is 32'hFFFF_FFFC.
